// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: bus widths, FSM
// states, start/ready encodings and a magnitude helper.
package div_unit_pkg;

  localparam int unsigned REG_BUS        = 32;
  localparam int unsigned DOUBLE_REG_BUS = 64;

  typedef logic [REG_BUS-1:0]        reg_bus_t;
  typedef logic [DOUBLE_REG_BUS-1:0] double_reg_bus_t;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Absolute value of a two's-complement operand when is_signed is set;
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic reg_bus_t magnitude(input reg_bus_t v, input logic is_signed);
    return (is_signed && v[REG_BUS-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor from the upper 33 bits, keep or restore, and shift in the quotient bit.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DOUBLE_REG_BUS-1:0] work,
  input  logic [REG_BUS-1:0]        divisor,
  output logic [DOUBLE_REG_BUS-1:0] next_work
);

  logic [REG_BUS:0] upper;
  logic             fits;

  // Trial subtraction and quotient-bit selection
  always_comb begin
    upper     = work[DOUBLE_REG_BUS-1:REG_BUS-1];
    fits      = (upper >= {1'b0, divisor});
    next_work = {fits ? (upper[REG_BUS-1:0] - divisor) : upper[REG_BUS-1:0],
                 work[REG_BUS-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for div/divu; returns {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: skip iteration when |op1| < |op2|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_t      state, state_n;
  logic [4:0]      cnt, cnt_n;
  double_reg_bus_t work, work_n, step;
  reg_bus_t        divisor, divisor_n;
  logic            sign1, sign1_n, sign2, sign2_n;
  double_reg_bus_t result_n;
  logic            ready_n;
  reg_bus_t        mag1, mag2, quo_fix, rem_fix;
  logic            abort;

  assign mag1  = magnitude(opdata1_i, signed_div_i);
  assign mag2  = magnitude(opdata2_i, signed_div_i);
  assign abort = annul_i || (start_i == DIV_STOP);

  div_step u_step (
    .work      (work),
    .divisor   (divisor),
    .next_work (step)
  );

  // Sign correction of the final iteration's quotient and remainder
  always_comb begin
    quo_fix = (sign1 ^ sign2) ? -step[REG_BUS-1:0] : step[REG_BUS-1:0];
    rem_fix = sign1 ? -step[DOUBLE_REG_BUS-1:REG_BUS] : step[DOUBLE_REG_BUS-1:REG_BUS];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    sign1_n   = sign1;
    sign2_n   = sign2;
    result_n  = result_o;
    ready_n   = ready_o;
    unique case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          // DIV_BY_ZERO is a short countdown that publishes work on expiry:
          // zero divisor waits two edges with work = 0, early exit waits one.
          if (opdata2_i == '0) begin
            state_n = DIV_BY_ZERO;
            work_n  = '0;
            cnt_n   = 5'd0;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (mag1 < mag2) begin
            state_n = DIV_BY_ZERO;
            work_n  = {opdata1_i, {REG_BUS{1'b0}}};
            cnt_n   = 5'd1;
          end
`endif
          else begin
            state_n   = DIV_ON;
            work_n    = {{REG_BUS{1'b0}}, mag1};
            divisor_n = mag2;
            sign1_n   = signed_div_i & opdata1_i[REG_BUS-1];
            sign2_n   = signed_div_i & opdata2_i[REG_BUS-1];
            cnt_n     = 5'd0;
          end
        end
      end
      DIV_BY_ZERO: begin
        if (abort) begin
          state_n = DIV_FREE;
          cnt_n   = 5'd0;
        end else if (cnt == 5'd1) begin
          state_n  = DIV_END;
          result_n = work;
          ready_n  = DIV_RESULT_READY;
          cnt_n    = 5'd0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      DIV_ON: begin
        if (abort) begin
          state_n = DIV_FREE;
          cnt_n   = 5'd0;
        end else begin
          work_n = step;
          cnt_n  = cnt + 5'd1;
          if (cnt == 5'd31) begin
            state_n  = DIV_END;
            result_n = {rem_fix, quo_fix};
            ready_n  = DIV_RESULT_READY;
            cnt_n    = 5'd0;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      sign1    <= sign1_n;
      sign2    <= sign2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, annul and reset
// sequences, and random requests against an arithmetic reference model.
// Honours DIV_EARLY_EXIT_EN for expected latency.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference quotient/remainder from plain integer arithmetic.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int unsigned lat_of(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (x < y) return 1;
`endif
    return 32;
  endfunction

  // Called right at the request's T0 edge; scrambles operands, waits for
  // ready, checks latency, result, hold in DIV_END and release.
  task automatic finish_req(input logic [63:0] exp, input int unsigned lat, input string name);
    int unsigned k;
    #1;
    check({name, " idle result"}, {ready_o, result_o[62:0]}, 64'd0);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    k = 0;
    while (ready_o !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, " latency"}, 64'(k), 64'(lat));
    check({name, " result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({name, " held"}, {31'd0, ready_o, result_o[31:0]}, {31'd0, 1'b1, exp[31:0]});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " released"}, {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    @(posedge clk);
    finish_req(exp, lat_of(sgn, a, b), name);
  endtask

  initial begin
    int unsigned ready_seen;
    logic        sgn;
    logic [31:0] a, b;

    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2}};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}};
    vecs[3]  = '{1'b0, 32'd1234,       32'd0,        64'd0};
    vecs[4]  = '{1'b1, 32'hFFFF_FF9C,  32'd0,        64'd0};
    vecs[5]  = '{1'b0, 32'd5,          32'd9,        {32'd5,        32'd0}};
    vecs[6]  = '{1'b1, 32'd100,        32'hFFFF_FFF9, {32'd2,        32'hFFFF_FFF2}};
    vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, {32'd0,        32'd1}};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'd0}};
    vecs[11] = '{1'b1, 32'hFFFF_FFFB,  32'd9,        {32'hFFFF_FFFB, 32'd0}};
    vecs[12] = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3}};
    vecs[13] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}};

    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {31'd0, ready_o, result_o[31:0]}, 64'd0);
    check("reset result hi", {32'd0, result_o[63:32]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int unsigned i = 0; i < 14; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Annul at T0+10 while start stays high, then a fresh 9/3 request.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("annul no ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    @(posedge clk);
    finish_req({32'd0, 32'd3}, 32, "after annul");

    // Synchronous reset at T0+20 aborts the request.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset outputs", {31'd0, ready_o, result_o[31:0]}, 64'd0);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1) ready_seen++;
    end
    check("no ready after reset", 64'(ready_seen), 64'd0);

    // Random requests against the reference model.
    for (int unsigned i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: b = 32'd0;
        2: b = $urandom_range(1, 15);
        default: begin
          a = $urandom_range(0, 200);
          b = $urandom_range(201, 100000);
        end
      endcase
      run_div(sgn, a, b, model(sgn, a, b), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
